// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame receiver feeding a byte FIFO, with optional key decoder
// Define PS2_RX_DECODE_EN to build the scan-code decoder (key_* outputs tie to 0 otherwise).
module ps2_rx_fifo #(
   parameter int FIFO_BITS = 3,
   parameter int TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full,
   output logic       overflow,
   output logic       frame_err,
   output logic       key_strobe,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release
);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam int DEPTH = 2 ** FIFO_BITS;
   localparam int PW    = FIFO_BITS + 1;
   localparam int TW    = $clog2(TIMEOUT + 1);

   state_t          r_state, w_state_nx;
   logic [2:0]      r_csync;
   logic [1:0]      r_dsync;
   logic [TW-1:0]   r_idle;
   logic [2:0]      r_cnt;
   logic [7:0]      r_sr;
   logic            r_par;
   logic            r_ferr;
   logic [PW-1:0]   r_wp, r_rp;
   logic            r_ov;
   logic [7:0]      r_mem [DEPTH];
   logic            w_fall, w_bit, w_tmo, w_push, w_ferr, w_rd, w_wr;

   // r_csync[2] is the previous synchronized clock value for edge detection
   assign w_fall = r_csync[2] & ~r_csync[1];
   assign w_bit  = r_dsync[1];
   assign w_tmo  = (r_state != IDLE) && !w_fall && (r_idle == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_csync <= '1;
         r_dsync <= '1;
         r_state <= IDLE;
      end else begin
         r_csync <= {r_csync[1:0], ps2_clk};
         r_dsync <= {r_dsync[0], ps2_data};
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_push     = 1'b0;
      w_ferr     = 1'b0;
      if (w_tmo) begin
         w_state_nx = IDLE;
         w_ferr     = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            IDLE:   w_state_nx = w_bit ? IDLE : DATA;
            DATA:   w_state_nx = (r_cnt == 3'd7) ? PARITY : DATA;
            PARITY: w_state_nx = STOP;
            STOP: begin
               w_state_nx = IDLE;
               w_push     = w_bit & (^{r_sr, r_par});
               w_ferr     = ~w_push;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle <= '0;
         r_cnt  <= '0;
         r_sr   <= '0;
         r_par  <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_idle <= (r_state == IDLE || w_fall || w_tmo) ? '0 : r_idle + TW'(1);
         r_ferr <= w_ferr;
         if (w_fall && r_state == IDLE) r_cnt <= '0;
         if (w_fall && r_state == DATA) begin
            r_sr  <= {w_bit, r_sr[7:1]};
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_fall && r_state == PARITY) r_par <= w_bit;
      end
   end

   assign frame_err = r_ferr;
   assign empty     = (r_wp == r_rp);
   assign full      = (r_wp[FIFO_BITS] != r_rp[FIFO_BITS]) &&
                      (r_wp[FIFO_BITS-1:0] == r_rp[FIFO_BITS-1:0]);
   assign w_rd      = rd & ~empty;
   assign w_wr      = w_push & (~full | w_rd);
   assign dout      = r_mem[r_rp[FIFO_BITS-1:0]];
   assign overflow  = r_ov;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp[FIFO_BITS-1:0]] <= r_sr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp <= '0;
         r_rp <= '0;
         r_ov <= 1'b0;
      end else begin
         if (w_wr) r_wp <= r_wp + PW'(1);
         if (w_rd) r_rp <= r_rp + PW'(1);
         if (w_push && !w_wr) r_ov <= 1'b1;
      end
   end

`ifdef PS2_RX_DECODE_EN
   logic       r_ext, r_rel, r_kstb, r_kext, r_krel;
   logic [7:0] r_kcode;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ext   <= 1'b0;
         r_rel   <= 1'b0;
         r_kstb  <= 1'b0;
         r_kext  <= 1'b0;
         r_krel  <= 1'b0;
         r_kcode <= '0;
      end else begin
         r_kstb <= 1'b0;
         if (w_wr) begin
            if (r_sr == 8'hE0) r_ext <= 1'b1;
            else if (r_sr == 8'hF0) r_rel <= 1'b1;
            else if (r_sr == 8'hE1) begin
               r_ext <= 1'b0;
               r_rel <= 1'b0;
            end else begin
               r_kstb  <= 1'b1;
               r_kcode <= r_sr;
               r_kext  <= r_ext;
               r_krel  <= r_rel;
               r_ext   <= 1'b0;
               r_rel   <= 1'b0;
            end
         end
      end
   end

   assign key_strobe  = r_kstb;
   assign key_code    = r_kcode;
   assign key_ext     = r_kext;
   assign key_release = r_krel;
`else
   assign key_strobe  = 1'b0;
   assign key_code    = 8'h00;
   assign key_ext     = 1'b0;
   assign key_release = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: random and directed PS/2 frames checked against a queue-based model.
module tb_ps2_rx_fifo;
   localparam int FB      = 3;
   localparam int DEPTH   = 2 ** FB;
   localparam int TIMEOUT = 4096;
   localparam int H       = 20;

   logic       clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1, rd = 0;
   logic [7:0] dout, key_code;
   logic       empty, full, overflow, frame_err, key_strobe, key_ext, key_release;

   int         n_cmp = 0, n_err = 0;
   int         ferr_cycles = 0, exp_ferr = 0;
   logic [9:0] strobes [$];
   logic [7:0] q [$];
   logic       m_ov = 0;

   ps2_rx_fifo #(.FIFO_BITS(FB), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd),
      .dout(dout), .empty(empty), .full(full), .overflow(overflow), .frame_err(frame_err),
      .key_strobe(key_strobe), .key_code(key_code), .key_ext(key_ext), .key_release(key_release)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) ferr_cycles++;
      if (key_strobe) strobes.push_back({key_ext, key_release, key_code});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; ps2_clk = 1; ps2_data = 1; rd = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      q.delete();
      m_ov = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (H) @(negedge clk);
         ps2_clk = 0;
         repeat (H) @(negedge clk);
         ps2_clk = 1;
      end
      ps2_data = 1;
      repeat (5) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      send(b, bad_par, bad_stop, 11);
      if (bad_par || bad_stop) exp_ferr++;
      else if (q.size() < DEPTH) q.push_back(b);
      else m_ov = 1;
   endtask

   task automatic pop(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (q.size() > 0) check("dout", dout, q.pop_front());
         else check("empty_rd", empty, 1);
         rd = 1;
         @(negedge clk);
         rd = 0;
      end
   endtask

   task automatic status(input string tag);
      @(negedge clk);
      check({tag, "_empty"}, empty, q.size() == 0);
      check({tag, "_full"}, full, q.size() == DEPTH);
      check({tag, "_ovf"}, overflow, m_ov);
      check({tag, "_ferr"}, ferr_cycles, exp_ferr);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_kstb", key_strobe, 0);
      check("rst_kcode", key_code, 0);
      do_reset();

      frame(8'h1C, 0, 0);
      status("good");
      pop(1);
      status("good_rd");
      pop(1);
      status("rd_empty");

      frame(8'h1C, 1, 0);
      status("badpar");
      frame(8'h3A, 0, 1);
      status("badstop");

      for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0);
      status("fill9");
      pop(DEPTH);
      status("drain");
      do_reset();

      send(8'hA5, 0, 0, 5);
      repeat (TIMEOUT + 10) @(negedge clk);
      exp_ferr++;
      frame(8'h55, 0, 0);
      status("timeout");
      pop(1);
      status("timeout_drain");

      send(8'h33, 0, 0, 6);
      do_reset();
      frame(8'h1C, 0, 0);
      status("midrst");
      pop(1);

      strobes.delete();
      frame(8'hE0, 0, 0);
      frame(8'hF0, 0, 0);
      frame(8'h75, 0, 0);
      frame(8'h1C, 0, 0);
      status("dec");
`ifdef PS2_RX_DECODE_EN
      check("dec_n", strobes.size(), 2);
      if (strobes.size() == 2) begin
         check("dec_k0", strobes[0], {2'b11, 8'h75});
         check("dec_k1", strobes[1], {2'b00, 8'h1C});
      end
`else
      check("dec_off", strobes.size(), 0);
`endif
      pop(4);
      status("dec_drain");
      do_reset();

      for (int it = 0; it < 40; it++) begin
         logic [7:0] b;
         int e;
         b = 8'($urandom);
         e = $urandom_range(0, 5);
         frame(b, e == 0, e == 1);
         status("rnd");
         if ($urandom_range(0, 2) == 0) pop($urandom_range(0, q.size() + 1));
      end
      pop(q.size() + 1);
      status("rnd_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_BITS, default 3: FIFO depth = 2**FIFO_BITS bytes.
REQ-002 SHALL have parameter TIMEOUT, default 4096: clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  PS/2 clock from user_io (ps2_kbd_clk/ps2_mouse_clk), asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  PS/2 data from user_io, asynchronous to clk.
REQ-007 SHALL have port rd  input  1  pop strobe, one byte per cycle high.
REQ-008 SHALL have port dout  output  8  FIFO head byte, valid while empty=0.
REQ-009 SHALL have port empty  output  1  FIFO holds no bytes.
REQ-010 SHALL have port full  output  1  FIFO holds 2**FIFO_BITS bytes.
REQ-011 SHALL have port overflow  output  1  sticky: a received byte was dropped.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse: bad start/parity/stop or timeout.
REQ-013 SHALL have ports key_strobe (output 1), key_code (output 8), key_ext (output 1), key_release (output 1): decoded key event (see Configuration).

Function
REQ-014 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; falling edge = synced prev 1, synced now 0.
REQ-015 SHALL sample synced ps2_data only on a falling edge; frame = start(0), 8 data LSB first, odd parity, stop(1).
REQ-016 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: edge with data=0 -> DATA, bit count 0; edge with data=1 -> stay IDLE, no error.
REQ-018 DATA: shift bit into bit 7 of shift register, right shift; after 8th bit -> PARITY.
REQ-019 PARITY: store bit -> STOP; parity OK iff XOR of 8 data bits and parity bit = 1.
REQ-020 STOP: always -> IDLE; if data=1 and parity OK, write byte to FIFO, else pulse frame_err for one cycle.
REQ-021 Outside IDLE, idle counter SHALL reset on each falling edge; on reaching TIMEOUT -> IDLE, frame_err pulses once, partial byte discarded.
REQ-022 FIFO write SHALL make empty=0 and dout valid on the cycle after the clk edge that registered the stop-bit falling edge.
REQ-023 rd while empty SHALL be ignored; rd advances head, dout shows next byte on the following cycle.
REQ-024 Write while full and no rd: byte dropped, overflow set to 1 until reset; write and rd same cycle while full: both accepted, full stays 1.
REQ-025 Pointers SHALL be FIFO_BITS+1 wide; full/empty from MSB compare; pointers wrap modulo 2**(FIFO_BITS+1).

Reset
REQ-026 reset SHALL asynchronously force: state IDLE, pointers 0, empty=1, full=0, overflow=0, frame_err=0, key_strobe=0, key_code=0, key_ext=0, key_release=0, prefix flags 0, synchronizers 1, idle counter 0.
REQ-027 reset mid-frame SHALL discard the partial frame without frame_err; after release the next start bit begins a fresh frame.

Configuration
REQ-028 Macro PS2_RX_DECODE_EN defined: decoder watches every byte written to the FIFO (independent of rd); 0xE0 sets ext flag, 0xF0 sets release flag, 0xE1 clears both flags with no event, any other byte pulses key_strobe one cycle with key_code=byte, key_ext/key_release = flags, then clears flags.
REQ-029 Macro PS2_RX_DECODE_EN undefined: decoder not built; key_strobe, key_code, key_ext, key_release tied 0; FIFO behaviour identical.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1 -> empty 1->0, dout=0x1C, frame_err stays 0; rd one cycle -> empty=1.
REQ-031 Frame 0x1C with parity 1 -> frame_err one-cycle pulse, empty stays 1.
REQ-032 9 valid frames 0x01..0x09, no rd (FIFO_BITS=3) -> full=1, overflow=1; 8 reads return 0x01..0x08, then empty=1.
REQ-033 Start + 4 data bits, then ps2_clk held high TIMEOUT+10 cycles, then frame 0x55 parity 1 -> one frame_err pulse, FIFO holds only 0x55.
REQ-034 With PS2_RX_DECODE_EN: frames E0, F0, 75 then 1C -> key_strobe twice: (0x75, ext=1, rel=1) then (0x1C, ext=0, rel=0); FIFO holds E0 F0 75 1C.
REQ-035 reset pulsed after 5 data bits, then frame 0x1C -> only 0x1C received, no frame_err.
